// File: rtl/nonce_stream_gen_if.sv
// rtl/nonce_stream_gen_if.sv - nonce output stream handshake (head data, valid, ready)
interface nonce_stream_gen_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] dataout;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output dataout,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  dataout,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/nonce_stream_gen.sv
// rtl/nonce_stream_gen.sv - counter/Galois-LFSR nonce source staged through a DEPTH-entry FIFO
// Optional period-exhaustion detection: NONCE_STREAM_WRAP_DET_EN
module nonce_stream_gen #(
    parameter int               WIDTH     = 32,
    parameter int               STEP      = 1,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 32'h80200003,
    parameter int               DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     mode,
    input  logic                     seed_load,
    input  logic [WIDTH-1:0]         seed,
    nonce_stream_gen_if.master       strm,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     wrapped
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_LAST = (AW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN, S_FULL} state_t;

    state_t           state;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] gen_next;
    logic [WIDTH-1:0] seed_val;
    logic             mode_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             load;
    logic             pop;
    logic             push;
    logic             blocked;

    assign load     = seed_load && (state != S_INIT);
    assign pop      = (count != '0) && strm.out_ready;
    assign push     = (state == S_RUN || state == S_FULL) && en && !seed_load && !blocked
                      && ((count != CNT_FULL) || pop);
    // An all-zero LFSR never leaves zero, so a zero seed in LFSR mode is promoted to 1.
    assign seed_val = (mode && seed == '0) ? WIDTH'(1) : seed;

    always_comb begin
        gen_next = gen + WIDTH'(STEP);
        if (mode_q)
            gen_next = gen[0] ? ((gen >> 1) ^ LFSR_TAPS) : (gen >> 1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_INIT;
            gen    <= '0;
            mode_q <= 1'b0;
            ready  <= 1'b0;
        end else if (state == S_INIT) begin
            state <= S_IDLE;
            ready <= 1'b1;
        end else if (load) begin
            gen   <= seed_val;
            state <= S_IDLE;
        end else begin
            if (push)
                gen <= gen_next;
            case (state)
                S_IDLE: if (en) begin
                    state  <= S_RUN;
                    mode_q <= mode;
                end
                S_RUN: begin
                    if (!en)
                        state <= S_IDLE;
                    else if (push && !pop && count == CNT_LAST)
                        state <= S_FULL;
                end
                S_FULL: begin
                    if (!en)
                        state <= S_IDLE;
                    else if (pop)
                        state <= S_RUN;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (load) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= gen;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    assign strm.dataout   = mem[rd_ptr];
    assign strm.out_valid = (count != '0);
    assign level          = count;

`ifdef NONCE_STREAM_WRAP_DET_EN
    logic [WIDTH-1:0] seed_q;
    logic             wrapped_q;

    // The push that would bring gen back to the loaded seed is the last one of the period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seed_q    <= '0;
            wrapped_q <= 1'b0;
        end else if (load) begin
            seed_q    <= seed_val;
            wrapped_q <= 1'b0;
        end else if (push && gen_next == seed_q) begin
            wrapped_q <= 1'b1;
        end
    end

    assign blocked = wrapped_q;
    assign wrapped = wrapped_q;
`else
    assign blocked = 1'b0;
    assign wrapped = 1'b0;
`endif
endmodule
